// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller:
// memory map sizes, word size and FSM state encoding.
package mem_access_ctrl_pkg;

    localparam int ROM_BYTES  = 1024;
    localparam int RAM_BYTES  = 1024;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_req_check.sv
// Combinational request legality decode: alignment, address range,
// ROM write protection and conflicting load+store enables.
module mem_access_ctrl_req_check
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              ren,
    input  logic              wen,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(ROM_BYTES + RAM_BYTES - WORD_BYTES);
    localparam logic [ADDR_W-1:0] ROM_END   = ADDR_W'(ROM_BYTES);

    logic misaligned;
    logic out_of_range;
    logic rom_write;
    logic both_ops;

    always_comb begin
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = (addr > LAST_WORD);
        rom_write    = wen && (addr < ROM_END);
        both_ops     = ren && wen;
        err          = misaligned || out_of_range || rom_write || both_ops;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: accepts one load/store, drives the memory
// port for WAIT_CYCLES cycles, then returns a one-cycle response.
//
// state    | meaning
// S_IDLE   | ready for a request, memory port idle
// S_ACCESS | memory port driven, wait counter running down to 0
// S_RESP   | resp_valid strobe, data/err presented
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              freeze,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_r_en,
    output logic              mem_w_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              load_q, load_d;
    logic              store_q, store_d;
    logic              err_q, err_d;

    logic              req_is_op;
    logic              accept;
    logic              chk_err;

    mem_access_ctrl_req_check #(
        .ADDR_W (ADDR_W)
    ) u_req_check (
        .addr (req_addr),
        .ren  (req_ren),
        .wen  (req_wen),
        .err  (chk_err)
    );

    assign req_is_op = req_valid && (req_ren || req_wen);
    assign accept    = (state_q == S_IDLE) && req_is_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            load_q  <= load_d;
            store_q <= store_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        load_d  = load_q;
        store_d = store_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = chk_err;
                    // Rejected requests never reach the port, so drop the op bits.
                    load_d  = req_ren && !chk_err;
                    store_d = req_wen && !chk_err;
                    cnt_d   = chk_err ? 4'd0 : CNT_INIT;
                    state_d = chk_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    if (load_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign freeze     = (state_q != S_IDLE) || req_is_op;
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_r_en   = (state_q == S_ACCESS) && load_q;
    // Single write pulse: only while the counter still holds its start value.
    assign mem_w_en   = (state_q == S_ACCESS) && store_q && (cnt_q == CNT_INIT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of single requests plus
// back-to-back, mid-access reset and non-memory request sequences.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_ren;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        freeze;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_rd_val;

    int total;
    int bad;

    mem_access_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .WAIT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ren    (req_ren),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .freeze     (freeze),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_rdata  (mem_rd_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rcnt;
        int          wcnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge; returns the observed response and port activity.
    task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mrd,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output int rcnt, output int wcnt, output int port_bad,
                          output logic timeout);
        logic got;
        got = 1'b0;
        lat = 0; err = 1'b0; rdata = '0; rcnt = 0; wcnt = 0; port_bad = 0;
        req_valid = 1'b1; req_ren = ren; req_wen = wen;
        req_addr = addr; req_wdata = wdata; mem_rd_val = mrd;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (mem_r_en) rcnt++;
            if (mem_w_en) wcnt++;
            if ((mem_r_en || mem_w_en) && (mem_addr !== addr)) port_bad++;
            if (mem_w_en && (mem_wdata !== wdata)) port_bad++;
            if (resp_valid) begin
                lat = n; err = resp_err; rdata = resp_rdata; got = 1'b1;
                break;
            end
        end
        req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
        timeout = !got;
        @(negedge clk);
        chk("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        int          lat, rcnt, wcnt, port_bad, seen;
        logic        err, timeout;
        logic [31:0] rdata;
        int          resp_n[2];
        logic        resp_e[2];
        logic [31:0] resp_d[2];
        int          resp_cnt, freeze_low;

        total = 0; bad = 0;
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,          32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3, 2, 0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'h0,          3, 0, 1};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hAAAA_0001, 32'h0,          1'b1, 32'h0,          1, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0402, 32'h0,          32'h1111_2222, 1'b1, 32'h0,          1, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0800, 32'h0,          32'h3333_4444, 1'b1, 32'h0,          1, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0400, 32'h5555_6666, 32'h7777_8888, 1'b1, 32'h0,          1, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,          32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 3, 2, 0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_07FC, 32'h0,          32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 3, 2, 0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h1111_1111, 1'b0, 32'h1111_1111, 3, 2, 0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_07FC, 32'hCAFE_BABE, 32'h9999_9999, 1'b0, 32'h0,          3, 0, 1};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_07FE, 32'h0101_0101, 32'h0,          1'b1, 32'h0,          1, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'h2222_3333, 1'b1, 32'h0,          1, 0, 0};

        rst_n = 1'b0; req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rd_val = '0;
        #2;
        chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err",   {31'b0, resp_err},   32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'd0);
        chk("rst_mem_r_en",   {31'b0, mem_r_en},   32'd0);
        chk("rst_mem_w_en",   {31'b0, mem_w_en},   32'd0);
        chk("rst_mem_addr",   mem_addr,            32'd0);
        chk("rst_freeze",     {31'b0, freeze},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'd1);
            do_req(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mrd,
                   lat, err, rdata, rcnt, wcnt, port_bad, timeout);
            chk($sformatf("v%0d_timeout", i), {31'b0, timeout}, 32'd0);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            chk($sformatf("v%0d_r_en_cycles", i), rcnt, vecs[i].rcnt);
            chk($sformatf("v%0d_w_en_cycles", i), wcnt, vecs[i].wcnt);
            chk($sformatf("v%0d_port_addr_data", i), port_bad, 32'd0);
        end

        // Back-to-back loads with req_valid held across the first response.
        resp_cnt = 0; freeze_low = 0;
        resp_n[0] = 0; resp_n[1] = 0; resp_e[0] = 1'b1; resp_e[1] = 1'b1;
        resp_d[0] = '0; resp_d[1] = '0;
        req_valid = 1'b1; req_ren = 1'b1; req_wen = 1'b0;
        req_addr = 32'h0000_0400; mem_rd_val = 32'hCAFE_0001;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (!freeze) freeze_low++;
            if (resp_valid) begin
                resp_n[resp_cnt] = n; resp_e[resp_cnt] = resp_err; resp_d[resp_cnt] = resp_rdata;
                resp_cnt++;
                if (resp_cnt == 1) begin
                    req_addr = 32'h0000_07FC; mem_rd_val = 32'hCAFE_0002;
                end else begin
                    break;
                end
            end
        end
        req_valid = 1'b0; req_ren = 1'b0;
        chk("b2b_resp_count", resp_cnt, 32'd2);
        chk("b2b_freeze_low_cycles", freeze_low, 32'd0);
        chk("b2b_first_latency", resp_n[0], 32'd3);
        chk("b2b_second_latency", resp_n[1], 32'd7);
        chk("b2b_first_err", {31'b0, resp_e[0]}, 32'd0);
        chk("b2b_second_err", {31'b0, resp_e[1]}, 32'd0);
        chk("b2b_first_rdata", resp_d[0], 32'hCAFE_0001);
        chk("b2b_second_rdata", resp_d[1], 32'hCAFE_0002);
        @(negedge clk);

        // Asynchronous reset in the second ACCESS cycle of a load.
        req_valid = 1'b1; req_ren = 1'b1; req_addr = 32'h0000_0404; mem_rd_val = 32'h5555_AAAA;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_pre_r_en", {31'b0, mem_r_en}, 32'd1);
        rst_n = 1'b0; req_valid = 1'b0; req_ren = 1'b0;
        #1;
        chk("mid_req_ready",  {31'b0, req_ready},  32'd1);
        chk("mid_mem_r_en",   {31'b0, mem_r_en},   32'd0);
        chk("mid_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_mem_addr",   mem_addr,            32'd0);
        chk("mid_resp_rdata", resp_rdata,          32'd0);
        chk("mid_freeze",     {31'b0, freeze},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("mid_no_resp", seen, 32'd0);
        do_req(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h600D_D00D,
               lat, err, rdata, rcnt, wcnt, port_bad, timeout);
        chk("post_rst_timeout", {31'b0, timeout}, 32'd0);
        chk("post_rst_latency", lat, 32'd3);
        chk("post_rst_err", {31'b0, err}, 32'd0);
        chk("post_rst_rdata", rdata, 32'h600D_D00D);
        chk("post_rst_r_en_cycles", rcnt, 32'd2);

        // req_valid without any enable is not a memory op.
        req_valid = 1'b1; req_ren = 1'b0; req_wen = 1'b0; req_addr = 32'h0000_0400;
        #1;
        chk("nop_freeze", {31'b0, freeze}, 32'd0);
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp_valid || !req_ready || freeze || mem_r_en || mem_w_en) seen++;
        end
        chk("nop_idle_quiet", seen, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
